// File: rtl/rgbw_wrd2sout.sv
// Drains G/R/B words from a FWFT FIFO and shifts them out as an SK6812-RGBW serial stream.
// Optional macro RGBW_WHITE_EXTRACT_EN enables min(G,R,B) white extraction; otherwise W=0.
`timescale 1ns/1ps
module rgbw_wrd2sout #(
    parameter int unsigned CLKS_BIT   = 120,
    parameter int unsigned CLKS_T0H   = 29,
    parameter int unsigned CLKS_T1H   = 58,
    parameter int unsigned CLKS_RESET = 7680
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_word,
    input  logic        in_rd_fifo_empty,
    output logic        out_rd_strobe,
    output logic        out_sdata,
    output logic        out_busy,
    output logic        out_underrun
);
    typedef enum logic [1:0] {IDLE, CONVERT, SEND_BIT, SEND_RESET} state_t;

    localparam logic [12:0] BIT_LAST  = 13'(CLKS_BIT - 1);
    localparam logic [12:0] T0H       = 13'(CLKS_T0H);
    localparam logic [12:0] T1H       = 13'(CLKS_T1H);
    localparam logic [12:0] RESET_LEN = 13'(CLKS_RESET);

    state_t      state, state_nxt;
    logic [31:0] hold, hold_nxt;
    logic [31:0] shift, shift_nxt;
    logic [12:0] cnt, cnt_nxt;
    logic [4:0]  bit_cnt, bit_nxt;
    logic        in_frame, frame_nxt;
    logic        strobe_nxt, sdata_nxt, underrun_nxt;
    logic [31:0] grbw;
    logic [7:0]  g, r, b;
    logic        unused_bits;

    assign g           = hold[23:16];
    assign r           = hold[15:8];
    assign b           = hold[7:0];
    assign unused_bits = ^hold[29:24];

`ifdef RGBW_WHITE_EXTRACT_EN
    logic [7:0] min_gr, w;
    assign min_gr = (g < r) ? g : r;
    assign w      = (min_gr < b) ? min_gr : b;
    assign grbw   = {g - w, r - w, b - w, w};
`else
    assign grbw   = {g, r, b, 8'h00};
`endif

    assign out_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            hold          <= '0;
            shift         <= '0;
            cnt           <= '0;
            bit_cnt       <= '0;
            in_frame      <= 1'b0;
            out_rd_strobe <= 1'b0;
            out_sdata     <= 1'b0;
            out_underrun  <= 1'b0;
        end else begin
            state         <= state_nxt;
            hold          <= hold_nxt;
            shift         <= shift_nxt;
            cnt           <= cnt_nxt;
            bit_cnt       <= bit_nxt;
            in_frame      <= frame_nxt;
            out_rd_strobe <= strobe_nxt;
            out_sdata     <= sdata_nxt;
            out_underrun  <= underrun_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold;
        shift_nxt    = shift;
        cnt_nxt      = cnt;
        bit_nxt      = bit_cnt;
        frame_nxt    = in_frame;
        strobe_nxt   = 1'b0;
        sdata_nxt    = 1'b0;
        underrun_nxt = out_underrun;
        case (state)
            IDLE: begin
                if (!in_rd_fifo_empty && !out_rd_strobe) begin
                    strobe_nxt = 1'b1;
                    hold_nxt   = in_word;
                    state_nxt  = CONVERT;
                end else if (in_rd_fifo_empty && in_frame) begin
                    underrun_nxt = 1'b1;
                    frame_nxt    = 1'b0;
                end
            end
            CONVERT: begin
                if (!hold[31]) begin
                    state_nxt = IDLE;
                end else if (hold[30]) begin
                    cnt_nxt   = RESET_LEN;
                    state_nxt = SEND_RESET;
                end else begin
                    shift_nxt = grbw;
                    bit_nxt   = 5'd31;
                    cnt_nxt   = '0;
                    state_nxt = SEND_BIT;
                end
            end
            SEND_BIT: begin
                // Registered output: the line trails the counter by one clock.
                sdata_nxt = (cnt < (shift[31] ? T1H : T0H));
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (bit_cnt == 5'd0) begin
                        frame_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        bit_nxt   = bit_cnt - 5'd1;
                        shift_nxt = {shift[30:0], 1'b0};
                    end
                end else begin
                    cnt_nxt = cnt + 13'd1;
                end
            end
            SEND_RESET: begin
                if (cnt <= 13'd1) begin
                    cnt_nxt   = '0;
                    frame_nxt = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 13'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/rgbw_wrd2sout.md
Name: rgbw_wrd2sout

Overview:
- Downstream of rgb_sbit2wrd; drains its 32-bit Status/Green/Red/Blue words from the write FIFO.
- Converts each valid word to GRBW by white extraction.
- Re-serialises the result as a 32-bit SK6812-RGBW bit stream on one output pin, 96 MHz clock.
- Words flagged stream-reset produce a line-low latch period instead of data.

Parameters:
- CLKS_BIT, 120, clocks per data bit (1.25 us at 96 MHz).
- CLKS_T0H, 29, high clocks for a "0" bit (~0.30 us).
- CLKS_T1H, 58, high clocks for a "1" bit (~0.60 us).
- CLKS_RESET, 7680, low clocks for a stream-reset/latch period (80 us).

Ports:
- clk  input  1  system clock, 96 MHz.
- rst  input  1  asynchronous, active-low reset; block held in reset while 0, released synchronously to clk.
- in_word  input  32  FIFO head word (first-word-fall-through); bit31 valid, bit30 stream_reset, [23:16] G, [15:8] R, [7:0] B.
- in_rd_fifo_empty  input  1  1 = in_word not valid.
- out_rd_strobe  output  1  one-clock pop of FIFO head.
- out_sdata  output  1  serial RGBW data to LED string.
- out_busy  output  1  1 whenever state is not IDLE.
- out_underrun  output  1  sticky: FIFO empty at a word boundary mid-frame.

Behaviour:
- Reset (rst=0, async): state IDLE; out_rd_strobe=0, out_sdata=0, out_busy=0, out_underrun=0; all counters 0; in_frame=0.
- States: IDLE, CONVERT, SEND_BIT, SEND_RESET.
- IDLE:
  - If in_rd_fifo_empty=0 and out_rd_strobe=0: assert out_rd_strobe for exactly 1 clock, capture in_word into hold register, go to CONVERT.
  - If empty and in_frame=1: set out_underrun=1 (sticky) and clear in_frame.
  - out_sdata=0.
- CONVERT (1 clock):
  - valid=0: discard word, return to IDLE.
  - stream_reset=1: load reset counter with CLKS_RESET, go to SEND_RESET. Data bits of that word are ignored.
  - Otherwise: W=min(G,R,B), G'=G-W, R'=R-W, B'=B-W (8-bit unsigned, no underflow possible). Shift register <= {G',R',B',W}, bit counter=31, clock counter=0, go to SEND_BIT.
- SEND_BIT:
  - Each bit lasts CLKS_BIT clocks. out_sdata=1 while clock counter < (msb ? CLKS_T1H : CLKS_T0H), else 0. Bits sent MSB first, order G',R',B',W.
  - After bit 0 completes: set in_frame=1, go to IDLE.
  - Inter-word gap of 2 clocks (IDLE+CONVERT) extends the last bit's low time; this is within protocol tolerance.
- SEND_RESET: out_sdata=0 for CLKS_RESET clocks, then clear in_frame, go to IDLE.
- Latency: first out_sdata rise occurs 2 clocks after out_rd_strobe.
- out_sdata is registered; no glitches.
- FIFO becoming non-empty at any point is only sampled in IDLE. No pop occurs during SEND_BIT or SEND_RESET.
- Simultaneous empty and frame end: underrun flagged in the IDLE cycle that sees empty.
- rst asserted mid-bit or mid-reset: out_sdata drops to 0 immediately (async). The partial word is lost and not re-popped.
- Counter widths: clock counter 13 bits (covers CLKS_RESET); bit counter 5 bits.

Optional Feature:
- Macro: RGBW_WHITE_EXTRACT_EN.
- Defined: white extraction as above.
- Undefined: W=0 and G/R/B are passed unmodified. Shift register <= {G,R,B,8'h00}. The min/subtract logic is not synthesised. All timing is unchanged.

Test Plan:
- Reset: hold rst=0, FIFO non-empty -> out_rd_strobe=0, out_sdata=0, out_busy=0, out_underrun=0. After release, first pop on the next IDLE clock.
- Conversion: word 0x80FF8040 -> out_rd_strobe 1 clock; serial 0xBF400040 (G'=BF, R'=40, B'=00, W=40). Each "1" bit is 58 high / 62 low; each "0" bit is 29 high / 91 low.
- Macro off: same word 0x80FF8040 -> serial 0xFF804000.
- Stream reset: word 0xC0123456 -> out_sdata low for exactly 7680 clocks, no data bits; out_underrun stays 0 when FIFO then empties.
- Invalid word 0x00ABCDEF -> popped, no out_sdata activity, back in IDLE 2 clocks later.
- Underrun: one data word, then FIFO empty -> out_underrun=1 one clock after bit 0 ends and stays 1. A later 0xC0000000 word is sent as a reset; out_underrun stays 1 until rst.
